// File: rtl/cfi_backend_sstack_pkg.sv
// Shared types for the CFI back-end shadow stack: the exception report record.
package cfi_backend_sstack_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] cause;
        logic [63:0] tval;
    } exception_t;

endpackage

// File: rtl/cfi_backend_sstack.sv
// Shadow-stack checker: drains the CFI log queue one entry per two cycles, pushes
// return addresses on calls and reports a latched fault on mismatched or empty returns.
module cfi_backend_sstack
    import cfi_backend_sstack_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH       = 16,
    parameter int FAULT_CAUSE = 18
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       queue_empty_i,
    output logic                       queue_pop_o,
    input  logic [1:0]                 log_kind_i,
    input  logic [XLEN-1:0]            log_pc_i,
    input  logic [XLEN-1:0]            log_target_i,
    input  logic                       log_rvc_i,
    input  logic                       fault_clear_i,
    output exception_t                 cfi_fault_o,
    output logic [1:0]                 fault_code_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     depth_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] KIND_CALL = 2'd2;
    localparam logic [1:0] KIND_RET  = 2'd3;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_UNDER    = 2'd2;

    localparam logic [XLEN-1:0]  LEN_RVC  = XLEN'(2);
    localparam logic [XLEN-1:0]  LEN_STD  = XLEN'(4);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_kind;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_target;
    logic             r_rvc;
    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_fault_valid;
    logic [1:0]       r_fault_code;
    logic [XLEN-1:0]  r_tval;
    logic             r_overflow;

    logic [XLEN-1:0]  w_link;
    logic [XLEN-1:0]  w_top;
    logic             w_push;

    assign w_link = r_pc + (r_rvc ? LEN_RVC : LEN_STD);
    assign w_top  = r_mem[r_wr_ptr - PTR_ONE];
    assign w_push = (r_state == S_EXEC) && (r_kind == KIND_CALL) && !rst_i;

    // The pop strobe is combinational so the fall-through queue advances in the same cycle.
    assign queue_pop_o = (r_state == S_IDLE) && !queue_empty_i && !rst_i;

    assign busy_o            = (r_state != S_IDLE);
    assign depth_o           = r_count;
    assign overflow_o        = r_overflow;
    assign fault_code_o      = r_fault_code;
    assign cfi_fault_o.valid = r_fault_valid;
    assign cfi_fault_o.cause = r_fault_valid ? 64'(FAULT_CAUSE) : 64'd0;
    assign cfi_fault_o.tval  = 64'(r_tval);

    // Stack storage: no reset, only the pointers below define occupancy.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_link;
        end
    end

    // Control FSM, log capture, stack pointers and the latched fault report.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_kind        <= 2'd0;
            r_pc          <= '0;
            r_target      <= '0;
            r_rvc         <= 1'b0;
            r_wr_ptr      <= '0;
            r_count       <= CNT_ZERO;
            r_fault_valid <= 1'b0;
            r_fault_code  <= CODE_NONE;
            r_tval        <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!queue_empty_i) begin
                        r_kind   <= log_kind_i;
                        r_pc     <= log_pc_i;
                        r_target <= log_target_i;
                        r_rvc    <= log_rvc_i;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    case (r_kind)
                        KIND_CALL: begin
                            r_wr_ptr <= r_wr_ptr + PTR_ONE;
                            // A full stack overwrites its oldest slot; occupancy saturates.
                            if (r_count == CNT_FULL) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_count <= r_count + CNT_ONE;
                            end
                        end
                        KIND_RET: begin
                            if (r_count == CNT_ZERO) begin
                                r_state       <= S_FAULT;
                                r_fault_valid <= 1'b1;
                                r_fault_code  <= CODE_UNDER;
                                r_tval        <= r_pc;
                            end else begin
                                r_wr_ptr <= r_wr_ptr - PTR_ONE;
                                r_count  <= r_count - CNT_ONE;
                                if (w_top != r_target) begin
                                    r_state       <= S_FAULT;
                                    r_fault_valid <= 1'b1;
                                    r_fault_code  <= CODE_MISMATCH;
                                    r_tval        <= r_target;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                S_FAULT: begin
                    if (fault_clear_i) begin
                        r_state       <= S_IDLE;
                        r_fault_valid <= 1'b0;
                        r_fault_code  <= CODE_NONE;
                        r_tval        <= '0;
                        r_wr_ptr      <= '0;
                        r_count       <= CNT_ZERO;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfi_backend_sstack.sv
// Directed bench for cfi_backend_sstack: a vector table of single log entries plus
// hand-written sequences for held-queue faults, overflow, pop cadence and reset.
module tb_cfi_backend_sstack;
    import cfi_backend_sstack_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             queue_empty = 1'b1;
    logic             queue_pop;
    logic [1:0]       log_kind = 2'd0;
    logic [XLEN-1:0]  log_pc = '0;
    logic [XLEN-1:0]  log_target = '0;
    logic             log_rvc = 1'b0;
    logic             fault_clear = 1'b0;
    exception_t       cfi_fault;
    logic [1:0]       fault_code;
    logic             busy;
    logic [4:0]       depth;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    cfi_backend_sstack #(.XLEN(XLEN), .DEPTH(DEPTH), .FAULT_CAUSE(18)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .queue_empty_i (queue_empty),
        .queue_pop_o   (queue_pop),
        .log_kind_i    (log_kind),
        .log_pc_i      (log_pc),
        .log_target_i  (log_target),
        .log_rvc_i     (log_rvc),
        .fault_clear_i (fault_clear),
        .cfi_fault_o   (cfi_fault),
        .fault_code_o  (fault_code),
        .busy_o        (busy),
        .depth_o       (depth),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] pc;
        logic [63:0] target;
        logic        rvc;
        logic        exp_valid;
        logic [1:0]  exp_code;
        logic [63:0] exp_tval;
        logic [4:0]  exp_depth;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one log entry in IDLE, scramble the inputs during EXEC, stop at the result cycle.
    task automatic txn(input logic [1:0] k, input logic [63:0] pc, input logic [63:0] tgt,
                       input logic rvc);
        log_kind = k; log_pc = pc; log_target = tgt; log_rvc = rvc;
        queue_empty = 1'b0;
        #1;
        chk("pop_in_idle", 64'(queue_pop), 64'd1);
        tick();
        queue_empty = 1'b1;
        log_kind = ~k; log_pc = ~pc; log_target = ~tgt; log_rvc = ~rvc;
        #1;
        chk("pop_in_exec", 64'(queue_pop), 64'd0);
        chk("busy_in_exec", 64'(busy), 64'd1);
        tick();
    endtask

    task automatic clear_fault();
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("clr_valid", 64'(cfi_fault.valid), 64'd0);
        chk("clr_code", 64'(fault_code), 64'd0);
        chk("clr_depth", 64'(depth), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd2, 64'h8000_0100, 64'h0, 1'b0, 1'b0, 2'd0, 64'h0, 5'd1};
        vecs[1]  = '{2'd3, 64'h8000_0180, 64'h8000_0104, 1'b0, 1'b0, 2'd0, 64'h0, 5'd0};
        vecs[2]  = '{2'd2, 64'h8000_0200, 64'h0, 1'b1, 1'b0, 2'd0, 64'h0, 5'd1};
        vecs[3]  = '{2'd3, 64'h8000_0280, 64'h8000_0300, 1'b0, 1'b1, 2'd1, 64'h8000_0300, 5'd0};
        vecs[4]  = '{2'd3, 64'h8000_0400, 64'h8000_0500, 1'b0, 1'b1, 2'd2, 64'h8000_0400, 5'd0};
        vecs[5]  = '{2'd0, 64'h8000_0600, 64'h8000_0700, 1'b0, 1'b0, 2'd0, 64'h0, 5'd0};
        vecs[6]  = '{2'd2, 64'h0000_1000, 64'h0, 1'b1, 1'b0, 2'd0, 64'h0, 5'd1};
        vecs[7]  = '{2'd1, 64'h0000_1100, 64'h0000_2000, 1'b0, 1'b0, 2'd0, 64'h0, 5'd1};
        vecs[8]  = '{2'd3, 64'h0000_2010, 64'h0000_1002, 1'b1, 1'b0, 2'd0, 64'h0, 5'd0};
        vecs[9]  = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0, 1'b0, 2'd0, 64'h0, 5'd1};
        vecs[10] = '{2'd3, 64'h0000_3000, 64'h0000_0000_0000_0002, 1'b0, 1'b0, 2'd0, 64'h0, 5'd0};

        // Reset: pop must stay low even with a nonempty queue.
        queue_empty = 1'b0;
        tick();
        chk("rst_pop", 64'(queue_pop), 64'd0);
        tick();
        queue_empty = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_fault", 64'(cfi_fault.valid), 64'd0);
        chk("rst_code", 64'(fault_code), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        for (int v = 0; v < 11; v++) begin
            txn(vecs[v].kind, vecs[v].pc, vecs[v].target, vecs[v].rvc);
            chk($sformatf("v%0d_depth", v), 64'(depth), 64'(vecs[v].exp_depth));
            chk($sformatf("v%0d_valid", v), 64'(cfi_fault.valid), 64'(vecs[v].exp_valid));
            chk($sformatf("v%0d_code", v), 64'(fault_code), 64'(vecs[v].exp_code));
            if (vecs[v].exp_valid) begin
                chk($sformatf("v%0d_cause", v), cfi_fault.cause, 64'd18);
                chk($sformatf("v%0d_tval", v), cfi_fault.tval, vecs[v].exp_tval);
                tick();
                chk($sformatf("v%0d_hold_code", v), 64'(fault_code), 64'(vecs[v].exp_code));
                chk($sformatf("v%0d_hold_tval", v), cfi_fault.tval, vecs[v].exp_tval);
                clear_fault();
            end
        end

        // Underflow fault with the queue held nonempty: no pops until cleared.
        txn(2'd3, 64'h8000_0400, 64'h0, 1'b0);
        chk("hold_code", 64'(fault_code), 64'd2);
        log_kind = 2'd0;
        queue_empty = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("hold_nopop", 64'(queue_pop), 64'd0);
            chk("hold_valid", 64'(cfi_fault.valid), 64'd1);
            tick();
        end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("resume_pop", 64'(queue_pop), 64'd1);
        tick();
        queue_empty = 1'b1;
        tick();
        chk("resume_idle", 64'(busy), 64'd0);

        // Overflow: DEPTH+1 calls, then DEPTH matching returns, then underflow.
        for (int i = 0; i <= DEPTH; i++) begin
            txn(2'd2, 64'(32'h100 * i), 64'h0, 1'b0);
            chk($sformatf("ovf_pulse_%0d", i), 64'(overflow), 64'(i == DEPTH));
            chk($sformatf("ovf_depth_%0d", i), 64'(depth), 64'((i < DEPTH) ? i + 1 : DEPTH));
        end
        tick();
        chk("ovf_pulse_end", 64'(overflow), 64'd0);
        for (int i = DEPTH; i >= 1; i--) begin
            txn(2'd3, 64'h9000, 64'(32'h100 * i + 4), 1'b0);
            chk($sformatf("ret_valid_%0d", i), 64'(cfi_fault.valid), 64'd0);
            chk($sformatf("ret_depth_%0d", i), 64'(depth), 64'(i - 1));
        end
        txn(2'd3, 64'h55, 64'h4, 1'b0);
        chk("ret0_code", 64'(fault_code), 64'd2);
        chk("ret0_tval", cfi_fault.tval, 64'h55);
        clear_fault();

        // Back-to-back branches: pop toggles every cycle, depth untouched.
        txn(2'd2, 64'h4000, 64'h0, 1'b0);
        log_kind = 2'd0;
        queue_empty = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk($sformatf("b2b_pop_%0d", j), 64'(queue_pop), 64'((j % 2) == 0));
            tick();
        end
        queue_empty = 1'b1;
        #1;
        chk("b2b_depth", 64'(depth), 64'd1);

        // Reset while in EXEC.
        log_kind = 2'd2;
        queue_empty = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rexec_pop", 64'(queue_pop), 64'd0);
        tick();
        queue_empty = 1'b1;
        rst = 1'b0;
        chk("rexec_busy", 64'(busy), 64'd0);
        chk("rexec_depth", 64'(depth), 64'd0);
        chk("rexec_ovf", 64'(overflow), 64'd0);

        // Reset while in FAULT.
        txn(2'd3, 64'h7000, 64'h0, 1'b0);
        chk("rflt_valid_pre", 64'(cfi_fault.valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rflt_valid", 64'(cfi_fault.valid), 64'd0);
        chk("rflt_cause", cfi_fault.cause, 64'd0);
        chk("rflt_tval", cfi_fault.tval, 64'd0);
        chk("rflt_code", 64'(fault_code), 64'd0);
        chk("rflt_busy", 64'(busy), 64'd0);
        chk("rflt_depth", 64'(depth), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
